// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execution-stage divider: state encoding,
// operand width, iteration count, counter width and a two's complement helper.
package mips_alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 6;

  // Counter value seen on the edge that performs the final restoring step.
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's complement negation; wraps for 0x80000000, which is what the
  // signed overflow case (0x80000000 / -1) relies on.
  function automatic logic [DIV_WIDTH-1:0] negate32(input logic [DIV_WIDTH-1:0] v);
    return ~v + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor and restore on borrow.
module div_step
  import mips_alu_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] remIn_i,
  input  logic                 dividendBit_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH-1:0] remOut_o,
  output logic                 quoBit_o
);

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH+1:0] diff;
  logic                 unusedTopBits;

  // The shifted remainder needs 33 bits; the extra top bit of the subtract
  // result is the borrow that decides between keeping the difference and
  // restoring. Either surviving value is below the divisor, so 32 bits hold it.
  assign shifted       = {remIn_i, dividendBit_i};
  assign diff          = {1'b0, shifted} - {2'b00, divisor_i};
  assign quoBit_o      = ~diff[DIV_WIDTH+1];
  assign remOut_o      = quoBit_o ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  assign unusedTopBits = diff[DIV_WIDTH] ^ shifted[DIV_WIDTH];

endmodule

// File: rtl/iter_div_x32.sv
// Iterative 32-bit restoring divider for DIV/DIVU with a Start/Busy/Done
// handshake: one quotient bit per clock, then a FIX cycle for sign correction.
// Optional feature macro: ITER_DIV_SIGNED_EN (signed DIV support). Without it
// every operation is DIVU and FIX only transfers the result to the outputs.
module iter_div_x32
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Clear,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  div_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 negQ_q, negQ_d;
  logic                 negR_q, negR_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] remOut_q, remOut_d;
  logic                 divZero_q, divZero_d;

  logic                 aNeg, bNeg;
  logic [DIV_WIDTH-1:0] aMag, bMag;
  logic [DIV_WIDTH-1:0] stepRem;
  logic                 stepBit;

`ifdef ITER_DIV_SIGNED_EN
  assign aNeg = Signed & A[DIV_WIDTH-1];
  assign bNeg = Signed & B[DIV_WIDTH-1];
`else
  // Signed is ignored here; the tied-low sign flags make FIX a plain copy.
  logic unusedSigned;
  assign unusedSigned = Signed;
  assign aNeg = 1'b0;
  assign bNeg = 1'b0;
`endif

  assign aMag = aNeg ? negate32(A) : A;
  assign bMag = bNeg ? negate32(B) : B;

  div_step u_step (
    .remIn_i      (rem_q),
    .dividendBit_i(dvd_q[DIV_WIDTH-1]),
    .divisor_i    (dvs_q),
    .remOut_o     (stepRem),
    .quoBit_o     (stepBit)
  );

  // Next-state logic: Clear beats everything, operands are only sampled in
  // IDLE/DONE, and the dividend register doubles as the quotient shifter.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    quo_d     = quo_q;
    remOut_d  = remOut_q;
    divZero_d = divZero_q;
    if (Clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (Start) begin
            if (B == '0) begin
              state_d   = DONE;
              quo_d     = '1;
              remOut_d  = A;
              divZero_d = 1'b1;
            end else begin
              state_d = CALC;
              dvd_d   = aMag;
              dvs_d   = bMag;
              rem_d   = '0;
              cnt_d   = '0;
              negQ_d  = aNeg ^ bNeg;
              negR_d  = aNeg;
            end
          end
        end
        CALC: begin
          rem_d = stepRem;
          dvd_d = {dvd_q[DIV_WIDTH-2:0], stepBit};
          cnt_d = cnt_q + DIV_CNT_W'(1);
          if (cnt_q == DIV_LAST) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quo_d     = negQ_q ? negate32(dvd_q) : dvd_q;
          remOut_d  = negR_q ? negate32(rem_q) : rem_q;
          divZero_d = 1'b0;
          state_d   = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      quo_q     <= '0;
      remOut_q  <= '0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      quo_q     <= quo_d;
      remOut_q  <= remOut_d;
      divZero_q <= divZero_d;
    end
  end

  assign Busy      = (state_q == CALC) || (state_q == FIX);
  assign Done      = (state_q == DONE);
  assign Quotient  = quo_q;
  assign Remainder = remOut_q;
  assign DivZero   = divZero_q;

endmodule

// File: tb/tb_iter_div_x32.sv
// Directed testbench for iter_div_x32: latency, unsigned/signed results,
// divide by zero, ignored Start, back-to-back issue, Clear and async reset.
module tb_iter_div_x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Signed;
  logic        Clear;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivZero;

  int compCount = 0;
  int failCount = 0;
  int doneCycle;
  int busyCycles;
  int doneSeen;

  always #5 clk = ~clk;

  iter_div_x32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Signed   (Signed),
    .Clear    (Clear),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivZero  (DivZero)
  );

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an operation from a falling edge and wait (bounded) for Done.
  // Cycle 1 is the cycle right after the accepting edge. If pulseAt is
  // non-zero, Start is re-asserted with a2/b2 during that cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input int pulseAt, input logic [31:0] a2, input logic [31:0] b2,
                               output int dCycle, output int bCycles);
    int cycle;
    A = a; B = b; Signed = s; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    cycle = 1;
    bCycles = 0;
    while (!Done && cycle < 100) begin
      if (Busy) bCycles++;
      if (cycle == pulseAt) begin
        Start = 1'b1; A = a2; B = b2;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      cycle++;
    end
    Start = 1'b0;
    dCycle = Done ? cycle : -1;
  endtask

  // Start an operation and stop at the falling edge inside cycle n.
  task automatic startAndWait(input logic [31:0] a, input logic [31:0] b, input int n);
    A = a; B = b; Signed = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Watch n cycles and count any Done pulses.
  task automatic watchDone(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (Done) seen++;
    end
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; Clear = 1'b0; A = '0; B = '0;
    #2;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_quo", Quotient, 0);
    checkOutput("rst_rem", Remainder, 0);
    checkOutput("rst_dz", DivZero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // DIVU 7/2
    applyStimulus(32'd7, 32'd2, 1'b0, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("u7_2_done_cycle", doneCycle, 34);
    checkOutput("u7_2_busy_cycles", busyCycles, 33);
    checkOutput("u7_2_busy_at_done", Busy, 0);
    checkOutput("u7_2_quo", Quotient, 32'd3);
    checkOutput("u7_2_rem", Remainder, 32'd1);
    checkOutput("u7_2_dz", DivZero, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", Done, 0);
    checkOutput("idle_busy", Busy, 0);

    // DIV -7/2
    applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("s_m7_2_done_cycle", doneCycle, 34);
`ifdef ITER_DIV_SIGNED_EN
    checkOutput("s_m7_2_quo", Quotient, 32'hFFFFFFFD);
    checkOutput("s_m7_2_rem", Remainder, 32'hFFFFFFFF);
`else
    checkOutput("s_m7_2_quo", Quotient, 32'h7FFFFFFC);
    checkOutput("s_m7_2_rem", Remainder, 32'h00000001);
`endif
    @(negedge clk);

    // 5/0
    applyStimulus(32'd5, 32'd0, 1'b0, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("dz_done_cycle", doneCycle, 1);
    checkOutput("dz_busy_cycles", busyCycles, 0);
    checkOutput("dz_busy_at_done", Busy, 0);
    checkOutput("dz_quo", Quotient, 32'hFFFFFFFF);
    checkOutput("dz_rem", Remainder, 32'd5);
    checkOutput("dz_flag", DivZero, 1);
    @(negedge clk);

    // DIV 0x80000000 / -1
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("ovf_done_cycle", doneCycle, 34);
    checkOutput("ovf_dz", DivZero, 0);
`ifdef ITER_DIV_SIGNED_EN
    checkOutput("ovf_quo", Quotient, 32'h80000000);
    checkOutput("ovf_rem", Remainder, 32'h00000000);
`else
    checkOutput("ovf_quo", Quotient, 32'h00000000);
    checkOutput("ovf_rem", Remainder, 32'h80000000);
`endif
    @(negedge clk);

    // DIV 7 / -2
    applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, 0, doneCycle, busyCycles);
`ifdef ITER_DIV_SIGNED_EN
    checkOutput("s7_m2_quo", Quotient, 32'hFFFFFFFD);
    checkOutput("s7_m2_rem", Remainder, 32'h00000001);
`else
    checkOutput("s7_m2_quo", Quotient, 32'h00000000);
    checkOutput("s7_m2_rem", Remainder, 32'h00000007);
`endif
    @(negedge clk);

    // 100/7 with Start re-pulsed (50/3) in cycle 10 of CALC
    applyStimulus(32'd100, 32'd7, 1'b0, 10, 32'd50, 32'd3, doneCycle, busyCycles);
    checkOutput("repulse_done_cycle", doneCycle, 34);
    checkOutput("repulse_quo", Quotient, 32'd14);
    checkOutput("repulse_rem", Remainder, 32'd2);

    // Back-to-back: Start issued during the Done cycle
    applyStimulus(32'hFFFFFFFF, 32'h10, 1'b0, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("b2b_done_cycle", doneCycle, 34);
    checkOutput("b2b_busy_cycles", busyCycles, 33);
    checkOutput("b2b_quo", Quotient, 32'h0FFFFFFF);
    checkOutput("b2b_rem", Remainder, 32'h0000000F);
    @(negedge clk);

    // Clear in cycle 15 of CALC
    startAndWait(32'd1000, 32'd3, 15);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    checkOutput("clr_busy", Busy, 0);
    checkOutput("clr_done", Done, 0);
    checkOutput("clr_quo_held", Quotient, 32'h0FFFFFFF);
    checkOutput("clr_rem_held", Remainder, 32'h0000000F);
    watchDone(40, doneSeen);
    checkOutput("clr_no_done", doneSeen, 0);

    // Asynchronous reset in cycle 15 of CALC, away from any edge
    startAndWait(32'd1000, 32'd3, 15);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", Busy, 0);
    checkOutput("arst_done", Done, 0);
    checkOutput("arst_quo", Quotient, 0);
    checkOutput("arst_rem", Remainder, 0);
    checkOutput("arst_dz", DivZero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watchDone(40, doneSeen);
    checkOutput("arst_no_done", doneSeen, 0);

    // Recovery after reset
    applyStimulus(32'd1000, 32'd3, 1'b0, 0, 0, 0, doneCycle, busyCycles);
    checkOutput("rec_done_cycle", doneCycle, 34);
    checkOutput("rec_quo", Quotient, 32'd333);
    checkOutput("rec_rem", Remainder, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
